// File: rtl/hamming_link_scheduler.sv
// Single-clock enable sequencer for the 15/11 Hamming link. It generates the serial capture,
// parallel load and serial transmit strobes, and overlaps capture of word n+1 with transmission of codeword n.
module hamming_link_scheduler #(
  parameter int IN_DIV    = 15,
  parameter int OUT_DIV   = 11,
  parameter int DATA_BITS = 11,
  parameter int CODE_BITS = 15
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       device_en,
  output logic       in_tick,
  output logic [3:0] in_idx,
  output logic       load_en,
  output logic       out_tick,
  output logic [3:0] out_idx,
  output logic       tx_active,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  // One period P spans a whole input word and a whole codeword.
  localparam int         P            = IN_DIV * DATA_BITS;
  localparam logic [7:0] PH_LAST      = 8'(P - 1);
  localparam logic [3:0] IN_CNT_LAST  = 4'(IN_DIV - 1);
  localparam logic [3:0] OUT_CNT_LAST = 4'(OUT_DIV - 1);
  localparam logic [3:0] IN_IDX_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0] OUT_IDX_LAST = 4'(CODE_BITS - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t     state, state_n;
  logic [7:0] ph, ph_n;
  logic [3:0] in_cnt, in_cnt_n, out_cnt, out_cnt_n;
  logic [3:0] in_idx_n, out_idx_n;
  logic       running, capture_n, transmit_n, load_n;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_n = state;
    unique case (state)
      IDLE:    if (device_en) state_n = FILL;
      FILL:    if (!device_en) state_n = IDLE;
               else if (ph == PH_LAST) state_n = STREAM;
      // A drop on the last phase has no frame left in flight, so there is nothing to drain.
      STREAM:  if (!device_en) state_n = (ph == PH_LAST) ? IDLE : DRAIN;
      DRAIN:   if (ph == PH_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Counters restart from zero whenever a run begins or ends.
    running    = (state != IDLE) && (state_n != IDLE);
    ph_n       = (!running || ph == PH_LAST) ? '0 : ph + 8'd1;
    in_cnt_n   = (!running || in_cnt == IN_CNT_LAST) ? '0 : in_cnt + 4'd1;
    out_cnt_n  = (!running || out_cnt == OUT_CNT_LAST) ? '0 : out_cnt + 4'd1;
    capture_n  = (state_n == FILL) || (state_n == STREAM);
    transmit_n = (state_n == STREAM) || (state_n == DRAIN);
    load_n     = (state_n == STREAM) && (ph_n == '0);

    in_idx_n = '0;
    if (running && capture_n)
      in_idx_n = !in_tick ? in_idx : (in_idx == IN_IDX_LAST) ? '0 : in_idx + 4'd1;
    out_idx_n = '0;
    if (running && transmit_n)
      out_idx_n = !out_tick ? out_idx : (out_idx == OUT_IDX_LAST) ? '0 : out_idx + 4'd1;
  end

  // Strobes are registered from next-state values so they line up with the cycle they describe.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rest) begin
      state      <= IDLE;
      ph         <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      in_idx     <= '0;
      out_idx    <= '0;
      in_tick    <= 1'b0;
      out_tick   <= 1'b0;
      load_en    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      tx_active  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      ph         <= ph_n;
      in_cnt     <= in_cnt_n;
      out_cnt    <= out_cnt_n;
      in_idx     <= in_idx_n;
      out_idx    <= out_idx_n;
      in_tick    <= capture_n && (in_cnt_n == IN_CNT_LAST);
      out_tick   <= transmit_n && (out_cnt_n == OUT_CNT_LAST);
      load_en    <= load_n;
      frame_done <= transmit_n && (ph_n == PH_LAST);
      frame_cnt  <= frame_cnt + {7'd0, load_n};
      tx_active  <= transmit_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule
